pattern_seq_store: RTL

- Parametrised successor to the Simon pattern storage; holds the growing colour sequence plus its own length, tail and read pointers.
- Supports three operations: append a symbol, play the sequence back over a valid/ready stream, and check player input symbol-by-symbol against the stored sequence.
- Sits between the game-control FSM (append/start/clear), the LED/tone driver (playback stream) and the button decoder (check input).

---
 rtl/pattern_pkg.sv | 16 +
 rtl/pattern_ram.sv | 21 ++
 rtl/pattern_seq_store.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the Simon-style pattern store.
package pattern_pkg;
  localparam int PAT_DATA_W = 2;
  localparam int PAT_DEPTH  = 64;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_CHECK
  } state_e;
endpackage

// File: rtl/pattern_ram.sv
// Sequence storage: synchronous write, asynchronous read, contents never reset.
module pattern_ram #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pattern_seq_store.sv
// Growing colour sequence with append, valid/ready playback and symbol-by-symbol check.
module pattern_seq_store
  import pattern_pkg::*;
#(
  parameter int DATA_W = PAT_DATA_W,
  parameter int DEPTH  = PAT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              append_en,
  input  logic [DATA_W-1:0] append_data,
  input  logic              play_start,
  output logic              play_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              play_last,
  input  logic              play_ready,
  input  logic              check_start,
  input  logic              check_en,
  input  logic [DATA_W-1:0] check_data,
  output logic              check_ok,
  output logic              check_done,
  output logic              check_fail,
  output logic              overflow,
  output logic [ADDR_W:0]   len,
  output logic              full,
  output logic              empty,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              play_valid_q, play_valid_d;
  logic              check_ok_q, check_ok_d;
  logic              check_done_q, check_done_d;
  logic              check_fail_q, check_fail_d;
  logic              overflow_q, overflow_d;
  logic              we;
  logic              at_last;
  logic [DATA_W-1:0] rd_data;

  assign full    = (len_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (len_q == '0);
  assign at_last = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1)));

  pattern_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(len_q[ADDR_W-1:0]),
    .wdata(append_data),
    .raddr(ptr_q),
    .rdata(rd_data)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    ptr_d        = ptr_q;
    check_ok_d   = 1'b0;
    check_done_d = 1'b0;
    check_fail_d = 1'b0;
    overflow_d   = 1'b0;
    we           = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      len_d   = '0;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Commands are mutually exclusive per cycle; losers are dropped.
          if (append_en) begin
            if (full) begin
              overflow_d = 1'b1;
            end else begin
              we    = 1'b1;
              len_d = len_q + (ADDR_W+1)'(1);
            end
          end else if (play_start && !empty) begin
            ptr_d   = '0;
            state_d = ST_PLAY;
          end else if (check_start && !empty) begin
            ptr_d   = '0;
            state_d = ST_CHECK;
          end
        end
        ST_PLAY: begin
          if (play_ready) begin
            if (at_last) state_d = ST_IDLE;
            else         ptr_d   = ptr_q + ADDR_W'(1);
          end
        end
        ST_CHECK: begin
          if (check_en) begin
            if (check_data != rd_data) begin
              check_fail_d = 1'b1;
              state_d      = ST_IDLE;
            end else if (at_last) begin
              check_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              check_ok_d = 1'b1;
              ptr_d      = ptr_q + ADDR_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    play_valid_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      ptr_q        <= '0;
      play_valid_q <= 1'b0;
      check_ok_q   <= 1'b0;
      check_done_q <= 1'b0;
      check_fail_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      play_valid_q <= play_valid_d;
      check_ok_q   <= check_ok_d;
      check_done_q <= check_done_d;
      check_fail_q <= check_fail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign play_valid = play_valid_q;
  assign play_data  = rd_data;
  assign play_last  = play_valid_q && at_last;
  assign check_ok   = check_ok_q;
  assign check_done = check_done_q;
  assign check_fail = check_fail_q;
  assign overflow   = overflow_q;
  assign len        = len_q;
  assign busy       = (state_q != ST_IDLE);
endmodule
